// File: rtl/noc_out_port_alloc.sv
// noc_out_port_alloc
//   Output-port unit of the NoC router: round-robin wormhole allocator,
//   crossbar mux and registered output stage. One instance per output.
//   A HEADER flit from a requesting input wins the port for its whole
//   packet. The packet ends on a TAIL flit or when the header length count
//   runs out, whichever comes first.
//
// Parameters
//   DATA_WIDTH  flit width; type at [DW-1:DW-3], length at [DW-4 -: LEN_W]
//   NUM_IN      number of competing inputs (2..8)
//   LEN_W       width of the packet-length field
//   WDOG_CYC    stall limit in cycles (only present with WATCHDOG_EN)
//
// Ports
//   clk, rst    clock; asynchronous active-high reset
//   req         input i routes its current packet to this output
//   in_valid    input i FIFO not empty
//   flit_in     FIFO head flits, input i at [i*DW +: DW]
//   rd_en       one-hot pop of the granted FIFO (combinational)
//   TX, RTS     registered flit and its one-cycle valid strobe
//   DCTS        downstream can accept a flit this cycle
//   busy        packet lock held
//   wdog_err    one-cycle stall-timeout pulse (WATCHDOG_EN only)
//
// Build option
//   WATCHDOG_EN  adds WDOG_CYC, wdog_err and the stall watchdog; without it
//                a stalled lock is held forever.
module noc_out_port_alloc #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_IN     = 5,
  parameter int LEN_W      = 12
`ifdef WATCHDOG_EN
  ,
  parameter int WDOG_CYC   = 256
`endif
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_IN-1:0]            req,
  input  logic [NUM_IN-1:0]            in_valid,
  input  logic [NUM_IN*DATA_WIDTH-1:0] flit_in,
  output logic [NUM_IN-1:0]            rd_en,
  output logic [DATA_WIDTH-1:0]        TX,
  output logic                         RTS,
  input  logic                         DCTS,
  output logic                         busy
`ifdef WATCHDOG_EN
  ,
  output logic                         wdog_err
`endif
);

  localparam int SEL_W = (NUM_IN > 2) ? $clog2(NUM_IN) : 1;
  localparam logic [2:0] FT_HEADER = 3'b001;
  localparam logic [2:0] FT_TAIL   = 3'b100;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                state, state_n;
  logic [SEL_W-1:0]      sel, sel_n;
  logic [SEL_W-1:0]      rr_ptr, rr_n;
  logic [SEL_W-1:0]      ptr_after_sel;
  logic [LEN_W-1:0]      cnt, cnt_n;
  logic                  hdr_pend, hdr_pend_n;
  logic [DATA_WIDTH-1:0] tx_n;
  logic                  rts_n;

  logic [DATA_WIDTH-1:0] flit_arr [NUM_IN];
  logic [NUM_IN-1:0]     eligible;
  logic                  grant_found;
  logic [SEL_W-1:0]      grant_idx;

  logic [DATA_WIDTH-1:0] cur_flit;
  logic [2:0]            cur_type;
  logic [LEN_W-1:0]      cur_len;
  logic                  xfer;
  logic                  eop;

`ifdef WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_CYC + 1);
  logic [WD_W-1:0] wd_cnt, wd_cnt_n;
  logic            wdog_n;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_in
      assign flit_arr[gi] = flit_in[gi*DATA_WIDTH +: DATA_WIDTH];
      assign eligible[gi] = req[gi] & in_valid[gi] &
                            (flit_arr[gi][DATA_WIDTH-1 -: 3] == FT_HEADER);
    end
  endgenerate

  assign cur_flit      = flit_arr[sel];
  assign cur_type      = cur_flit[DATA_WIDTH-1 -: 3];
  assign cur_len       = cur_flit[DATA_WIDTH-4 -: LEN_W];
  assign ptr_after_sel = (sel == SEL_W'(NUM_IN - 1)) ? '0 : sel + 1'b1;
  assign busy          = (state == BUSY);

  // Round-robin search: first eligible input at or after rr_ptr, wrapping.
  always_comb begin
    int unsigned      idx;
    logic [SEL_W-1:0] idx_s;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    idx_s       = '0;
    for (int unsigned k = 0; k < unsigned'(NUM_IN); k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= unsigned'(NUM_IN)) idx = idx - unsigned'(NUM_IN);
      idx_s = SEL_W'(idx);
      if (!grant_found && eligible[idx_s]) begin
        grant_found = 1'b1;
        grant_idx   = idx_s;
      end
    end
  end

  always_comb begin
    state_n    = state;
    sel_n      = sel;
    rr_n       = rr_ptr;
    cnt_n      = cnt;
    hdr_pend_n = hdr_pend;
    tx_n       = TX;
    rts_n      = 1'b0;
    rd_en      = '0;
    xfer       = 1'b0;
    eop        = 1'b0;
`ifdef WATCHDOG_EN
    wd_cnt_n   = '0;
    wdog_n     = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (grant_found) begin
          sel_n      = grant_idx;
          hdr_pend_n = 1'b1;
          state_n    = BUSY;
        end
      end
      BUSY: begin
        xfer = DCTS & in_valid[sel];
        if (xfer) begin
          rd_en[sel] = 1'b1;
          tx_n       = cur_flit;
          rts_n      = 1'b1;
          hdr_pend_n = 1'b0;
          // hdr_pend marks the header transfer: it loads the count instead
          // of decrementing it; length 0 or 1 means header-only.
          if (hdr_pend) begin
            cnt_n = cur_len - LEN_W'(1);
            eop   = (cur_len <= LEN_W'(1));
          end else begin
            cnt_n = cnt - LEN_W'(1);
            eop   = (cnt == LEN_W'(1));
          end
          if (cur_type == FT_TAIL) eop = 1'b1;
          if (eop) begin
            state_n = IDLE;
            rr_n    = ptr_after_sel;
          end
        end
`ifdef WATCHDOG_EN
        else begin
          if (wd_cnt == WD_W'(WDOG_CYC - 1)) begin
            wdog_n  = 1'b1;
            state_n = IDLE;
            rr_n    = ptr_after_sel;
          end else begin
            wd_cnt_n = wd_cnt + 1'b1;
          end
        end
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sel      <= '0;
      rr_ptr   <= '0;
      cnt      <= '0;
      hdr_pend <= 1'b0;
      TX       <= '0;
      RTS      <= 1'b0;
    end else begin
      state    <= state_n;
      sel      <= sel_n;
      rr_ptr   <= rr_n;
      cnt      <= cnt_n;
      hdr_pend <= hdr_pend_n;
      TX       <= tx_n;
      RTS      <= rts_n;
    end
  end

`ifdef WATCHDOG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt   <= '0;
      wdog_err <= 1'b0;
    end else begin
      wd_cnt   <= wd_cnt_n;
      wdog_err <= wdog_n;
    end
  end
`endif

endmodule

// File: tb/tb_noc_out_port_alloc.sv
// Self-checking bench for noc_out_port_alloc (NUM_IN=5, DATA_WIDTH=32).
// The bench owns per-input FIFO queues and pops them on rd_en. The
// reference model works at packet level: starting from the round-robin
// pointer it picks the next requesting input whose head is a HEADER and
// moves that whole packet (length/TAIL rules) into the expected TX stream.
module tb_noc_out_port_alloc;
  localparam int DW = 32;
  localparam int N  = 5;
  localparam int LW = 12;
  localparam int WD = 16;
  localparam logic [2:0] T_HDR  = 3'b001;
  localparam logic [2:0] T_BODY = 3'b010;
  localparam logic [2:0] T_TAIL = 3'b100;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req, in_valid, rd_en;
  logic [N*DW-1:0] flit_in;
  logic [DW-1:0] TX;
  logic          RTS, DCTS, busy;
`ifdef WATCHDOG_EN
  logic          wdog_err;
`endif

  logic [DW-1:0] fq [N][$];
  logic [DW-1:0] mq [N][$];
  logic [DW-1:0] exp_q [$];
  logic [N-1:0]  req_mask;
  int vectors = 0;
  int miscompares = 0;
  int rts_cnt, first_rts, last_rts, exp_cycles;

  always #5 clk = ~clk;

  noc_out_port_alloc #(
    .DATA_WIDTH(DW),
    .NUM_IN(N),
    .LEN_W(LW)
`ifdef WATCHDOG_EN
    ,
    .WDOG_CYC(WD)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .in_valid(in_valid),
    .flit_in(flit_in),
    .rd_en(rd_en),
    .TX(TX),
    .RTS(RTS),
    .DCTS(DCTS),
    .busy(busy)
`ifdef WATCHDOG_EN
    ,
    .wdog_err(wdog_err)
`endif
  );

  function automatic logic [2:0] ftype(input logic [DW-1:0] f);
    return f[DW-1 -: 3];
  endfunction

  function automatic logic [LW-1:0] flen(input logic [DW-1:0] f);
    return f[DW-4 -: LW];
  endfunction

  // Header carrying len_field, then nflits-1 more flits; the last one is
  // TAIL when with_tail is set, otherwise BODY (count-terminated packet).
  task automatic push_pkt(input int src, input int len_field, input int nflits,
                          input bit with_tail);
    logic [DW-1:0] f;
    for (int k = 0; k < nflits; k++) begin
      f[16:0] = {3'(src), 14'($urandom)};
      if (k == 0) begin
        f[31:29] = T_HDR;
        f[28:17] = 12'(len_field);
      end else begin
        f[31:29] = (k == nflits - 1 && with_tail) ? T_TAIL : T_BODY;
        f[28:17] = 12'($urandom);
      end
      fq[src].push_back(f);
    end
  endtask

  task automatic build_expected(input int start_ptr);
    int ptr, found, len, n;
    logic [DW-1:0] f;
    ptr = start_ptr;
    for (int i = 0; i < N; i++) mq[i] = fq[i];
    exp_q.delete();
    exp_cycles = 0;
    forever begin
      found = -1;
      for (int k = 0; k < N; k++) begin
        int i;
        i = (ptr + k) % N;
        if (found < 0 && req_mask[i] && mq[i].size() > 0 && ftype(mq[i][0]) == T_HDR)
          found = i;
      end
      if (found < 0) break;
      f = mq[found].pop_front();
      exp_q.push_back(f);
      len = int'(flen(f));
      if (len == 0) len = 1;
      n = 1;
      while (n < len && mq[found].size() > 0) begin
        f = mq[found].pop_front();
        exp_q.push_back(f);
        n++;
        if (ftype(f) == T_TAIL) break;
      end
      exp_cycles += n + 1;   // one grant cycle plus one cycle per flit
      ptr = (found + 1) % N;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    req = '0; in_valid = '0; flit_in = '0; DCTS = 1'b0;
    for (int i = 0; i < N; i++) fq[i].delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // mode 0: DCTS high; 1: DCTS low in cycles 3..6; 2: random DCTS.
  // Returns early once stop_rts flits were seen (stop_rts > 0).
  task automatic run(input int max_cyc, input int mode, input bit bubbles,
                     input int stop_rts);
    logic [N-1:0]  prev_rd;
    logic [DW-1:0] e, junk;
    int cyc, idle_after;
    prev_rd = '0; rts_cnt = 0; first_rts = -1; last_rts = -1;
    cyc = 0; idle_after = 0;
    forever begin
      case (mode)
        0:       DCTS = 1'b1;
        1:       DCTS = !(cyc >= 3 && cyc <= 6);
        default: DCTS = ($urandom_range(0, 3) != 0);
      endcase
      req = req_mask;
      for (int i = 0; i < N; i++) begin
        if (fq[i].size() > 0) begin
          flit_in[i*DW +: DW] = fq[i][0];
          in_valid[i] = !(bubbles && ftype(fq[i][0]) != T_HDR && $urandom_range(0, 3) == 0);
        end else begin
          flit_in[i*DW +: DW] = '0;
          in_valid[i] = 1'b0;
        end
      end
      @(negedge clk);
      vectors++;
      if ($onehot0(rd_en) !== 1'b1) begin
        miscompares++;
        $display("FAIL rd_en_onehot cyc=%0d got=%b want=at most one bit", cyc, rd_en);
      end
      vectors++;
      if ((rd_en & ~(in_valid & {N{DCTS}})) !== '0) begin
        miscompares++;
        $display("FAIL rd_en_legal cyc=%0d rd_en=%b in_valid=%b DCTS=%b want=no pop", cyc, rd_en, in_valid, DCTS);
      end
      if (rd_en != '0) begin
        vectors++;
        if (busy !== 1'b1) begin
          miscompares++;
          $display("FAIL busy_on_pop cyc=%0d got=%b want=1", cyc, busy);
        end
      end
      vectors++;
      if (RTS !== (prev_rd != '0)) begin
        miscompares++;
        $display("FAIL rts_timing cyc=%0d got=%b want=%b", cyc, RTS, (prev_rd != '0));
      end
      if (RTS === 1'b1) begin
        rts_cnt++;
        if (first_rts < 0) first_rts = cyc;
        last_rts = cyc;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL tx_extra cyc=%0d got=%h want=no flit", cyc, TX);
        end else begin
          e = exp_q.pop_front();
          if (TX !== e) begin
            miscompares++;
            $display("FAIL tx_flit cyc=%0d got=%h want=%h", cyc, TX, e);
          end
        end
      end
`ifdef WATCHDOG_EN
      vectors++;
      if (wdog_err !== 1'b0) begin
        miscompares++;
        $display("FAIL wdog_spurious cyc=%0d got=%b want=0", cyc, wdog_err);
      end
`endif
      if (stop_rts > 0 && rts_cnt == stop_rts) return;
      if (exp_q.size() == 0) idle_after++;
      if (idle_after > 3) begin
        vectors++;
        if (busy !== 1'b0) begin
          miscompares++;
          $display("FAIL busy_end cyc=%0d got=%b want=0", cyc, busy);
        end
        return;
      end
      if (cyc >= max_cyc) begin
        vectors++;
        miscompares++;
        $display("FAIL timeout cyc=%0d flits_left=%0d want=0", cyc, exp_q.size());
        return;
      end
      prev_rd = rd_en;
      @(posedge clk);
      for (int i = 0; i < N; i++)
        if (prev_rd[i] && fq[i].size() > 0) junk = fq[i].pop_front();
      #1;
      cyc++;
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = '1; in_valid = '1; DCTS = 1'b1;
    for (int i = 0; i < N; i++) flit_in[i*DW +: DW] = {T_HDR, 12'd3, 17'(i)};
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors += 4;
    if (TX !== '0)    begin miscompares++; $display("FAIL reset_tx got=%h want=0", TX); end
    if (RTS !== 1'b0) begin miscompares++; $display("FAIL reset_rts got=%b want=0", RTS); end
    if (rd_en !== '0) begin miscompares++; $display("FAIL reset_rd_en got=%b want=0", rd_en); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b want=0", busy); end
`ifdef WATCHDOG_EN
    vectors++;
    if (wdog_err !== 1'b0) begin miscompares++; $display("FAIL reset_wdog got=%b want=0", wdog_err); end
`endif
    apply_reset();
  endtask

  task automatic test_round_robin();
    apply_reset();
    req_mask = '1;
    for (int i = 0; i < N; i++) push_pkt(i, 3, 3, 1'b1);
    push_pkt(0, 3, 3, 1'b1);
    build_expected(0);
    run(200, 0, 1'b0, 0);
    check_int("rr_rts_count", rts_cnt, 18);
    check_int("rr_first_latency", first_rts, 2);
    check_int("rr_last_rts", last_rts, 24);
  endtask

  task automatic test_backpressure();
    apply_reset();
    req_mask = '1;
    push_pkt(2, 4, 4, 1'b1);
    build_expected(0);
    run(100, 1, 1'b0, 0);
    check_int("bp_rts_count", rts_cnt, 4);
    check_int("bp_last_rts", last_rts, 9);
  endtask

  task automatic test_len1();
    apply_reset();
    req_mask = '1;
    push_pkt(1, 1, 1, 1'b1);
    push_pkt(1, 1, 1, 1'b1);
    push_pkt(2, 2, 2, 1'b1);
    build_expected(0);
    run(100, 0, 1'b0, 0);
    check_int("len1_rts_count", rts_cnt, 4);
    check_int("len1_last_rts", last_rts, 7);
  endtask

  task automatic test_early_tail();
    apply_reset();
    req_mask = '1;
    push_pkt(3, 8, 3, 1'b1);
    push_pkt(4, 2, 2, 1'b0);
    build_expected(0);
    run(100, 0, 1'b0, 0);
    check_int("tail_rts_count", rts_cnt, 5);
    check_int("tail_last_rts", last_rts, exp_cycles);
  endtask

  task automatic test_reset_mid_packet();
    apply_reset();
    req_mask = '1;
    push_pkt(0, 5, 5, 1'b1);
    push_pkt(1, 2, 2, 1'b1);
    build_expected(0);
    run(100, 0, 1'b0, 2);
    #1 rst = 1'b1;
    #1;
    vectors += 3;
    if (RTS !== 1'b0)  begin miscompares++; $display("FAIL midrst_rts got=%b want=0", RTS); end
    if (rd_en !== '0)  begin miscompares++; $display("FAIL midrst_rd_en got=%b want=0", rd_en); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy got=%b want=0", busy); end
    apply_reset();
    push_pkt(1, 2, 2, 1'b1);
    push_pkt(0, 3, 3, 1'b1);
    build_expected(0);
    run(100, 0, 1'b0, 0);
    check_int("midrst_rts_count", rts_cnt, 5);
    check_int("midrst_last_rts", last_rts, 7);
  endtask

  task automatic test_random();
    int npk, kind, len, nexp;
    for (int r = 0; r < 4; r++) begin
      apply_reset();
      req_mask = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        npk = $urandom_range(0, 3);
        for (int p = 0; p < npk; p++) begin
          kind = $urandom_range(0, 3);
          case (kind)
            0: begin len = $urandom_range(1, 5); push_pkt(i, len, len, 1'b1); end
            1: push_pkt(i, 0, 1, 1'b1);
            2: begin len = $urandom_range(2, 4); push_pkt(i, len + $urandom_range(1, 6), len, 1'b1); end
            default: begin len = $urandom_range(2, 5); push_pkt(i, len, len, 1'b0); end
          endcase
        end
      end
      build_expected(0);
      nexp = exp_q.size();
      run(3000, 2, 1'b1, 0);
      check_int("rand_rts_count", rts_cnt, nexp);
    end
  endtask

`ifdef WATCHDOG_EN
  task automatic test_watchdog();
    int c_h, c_w;
    logic [N-1:0]  popped;
    logic [DW-1:0] junk;
    apply_reset();
    req_mask = '1;
    push_pkt(0, 4, 1, 1'b1);
    c_h = -1; c_w = -1;
    for (int c = 0; c < 100 && c_w < 0; c++) begin
      req = req_mask; DCTS = 1'b1; flit_in = '0;
      in_valid = (fq[0].size() > 0) ? N'(1) : '0;
      if (fq[0].size() > 0) flit_in[DW-1:0] = fq[0][0];
      @(negedge clk);
      if (rd_en[0] === 1'b1 && c_h < 0) c_h = c;
      if (wdog_err === 1'b1) begin
        c_w = c;
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL wdog_busy got=%b want=0", busy); end
      end
      popped = rd_en;
      @(posedge clk);
      if (popped[0] && fq[0].size() > 0) junk = fq[0].pop_front();
      #1;
    end
    check_int("wdog_seen", (c_w >= 0) ? 1 : 0, 1);
    check_int("wdog_delay", c_w - c_h, WD + 1);
    @(negedge clk);
    vectors++;
    if (wdog_err !== 1'b0) begin miscompares++; $display("FAIL wdog_width got=%b want=0", wdog_err); end
    @(posedge clk);
    #1;
    push_pkt(0, 2, 2, 1'b1);
    push_pkt(1, 2, 2, 1'b1);
    build_expected(1);
    run(100, 0, 1'b0, 0);
    check_int("wdog_rr_count", rts_cnt, 4);
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_backpressure();
    test_len1();
    test_early_tail();
    test_reset_mid_packet();
    test_random();
`ifdef WATCHDOG_EN
    test_watchdog();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout reached want=finish earlier");
    $fatal(1);
  end
endmodule
